// File: rtl/pedal_pkg.sv
// -----------------------------------------------------------------------------
// pedal_pkg
//   Definitions shared across the pedal datapath.
//   - SAMPLE_W       : native sample width of the converter path.
//   - frame_state_t  : phases of one converter SPI frame.
//   - offset_to_twos : offset-binary to two's complement (MSB inversion).
//                      The DAC-side formatting uses the same function.
// -----------------------------------------------------------------------------
package pedal_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } frame_state_t;

  // Offset-binary and two's complement differ only in the sign bit.
  function automatic logic [SAMPLE_W-1:0] offset_to_twos(input logic [SAMPLE_W-1:0] word);
    return {~word[SAMPLE_W-1], word[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   Generates the SPI clock for the frame engine. Each sclk half-period lasts
//   CLK_DIV clk cycles, and the low phase always comes first. While en is low,
//   the divider is cleared and sclk is parked low.
//
// Ports
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   en       in   run the divider (high for the whole shift phase)
//   sclk     out  registered SPI clock, idle low
//   rise_evt out  high in the cycle whose closing clk edge raises sclk
//   fall_evt out  high in the cycle whose closing clk edge lowers sclk
// -----------------------------------------------------------------------------
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             sclk_reg;
  logic             half_done;

  // The strobes announce the edge that the next clk edge produces. The owner
  // can then act on the same clk edge on which sclk actually toggles.
  assign half_done = en && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign rise_evt  = half_done && !sclk_reg;
  assign fall_evt  = half_done && sclk_reg;
  assign sclk      = sclk_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (half_done) begin
      div_cnt_reg <= '0;
      sclk_reg    <= ~sclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_sample_frame.sv
// -----------------------------------------------------------------------------
// spi_sample_frame
//   Converter-side SPI frame engine. Each rising edge of adc_clock runs one
//   full-duplex DATA_W-bit mode-0 transfer. The transfer shifts dac_in out on
//   mosi (MSB first) and captures the ADC word from miso. The captured word is
//   converted to two's complement when SIGNED_CONV is set and presented on
//   adc_out with a 1-cycle adc_valid strobe.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   adc_clock  in   sample tick level; a 0->1 transition starts a frame
//   dac_in     in   word to transmit, latched at frame start
//   miso       in   serial data from the ADC
//   mosi       out  serial data to the DAC, MSB first
//   sclk       out  SPI clock, idle low
//   cs_n       out  converter chip select, active low
//   adc_out    out  last captured sample
//   adc_valid  out  1-cycle pulse when adc_out updates
//   busy       out  high from frame start through DONE
//   overrun    out  1-cycle pulse when a tick edge arrives mid-frame
//
// Frame latency from the trigger edge to adc_valid:
//   CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD + 1 cycles.
// -----------------------------------------------------------------------------
module spi_sample_frame
  import pedal_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int SIGNED_CONV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_clock,
  input  logic [DATA_W-1:0] dac_in,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic              cs_n,
  output logic [DATA_W-1:0] adc_out,
  output logic              adc_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  frame_state_t      state_reg;
  logic              adc_clock_q_reg;
  logic              armed_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [BIT_W-1:0]  bit_reg;

  logic              mosi_reg;
  logic              cs_n_reg;
  logic [DATA_W-1:0] adc_out_reg;
  logic              adc_valid_reg;
  logic              busy_reg;
  logic              overrun_reg;

  logic              trigger;
  logic              rise_evt;
  logic              fall_evt;
  logic              shift_en;
  logic [DATA_W-1:0] rx_conv;

  // armed_reg is loaded during reset with ~adc_clock. If the tick is already
  // high when reset releases, the cleared edge register must not read this as
  // a rising edge. From the first running cycle on, adc_clock_q_reg holds
  // real history, so the gate opens permanently.
  assign trigger  = adc_clock && !adc_clock_q_reg && armed_reg;
  assign shift_en = (state_reg == SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (shift_en),
    .sclk     (sclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  generate
    if (SIGNED_CONV != 0 && DATA_W == SAMPLE_W) begin : g_conv_pkg
      assign rx_conv = offset_to_twos(rx_reg);
    end else if (SIGNED_CONV != 0) begin : g_conv_inline
      assign rx_conv = {~rx_reg[DATA_W-1], rx_reg[DATA_W-2:0]};
    end else begin : g_conv_pass
      assign rx_conv = rx_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      adc_clock_q_reg <= 1'b0;
      armed_reg       <= ~adc_clock;
      tx_reg          <= '0;
      rx_reg          <= '0;
      cnt_reg         <= '0;
      bit_reg         <= '0;
      mosi_reg        <= 1'b0;
      cs_n_reg        <= 1'b1;
      adc_out_reg     <= '0;
      adc_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      adc_clock_q_reg <= adc_clock;
      armed_reg       <= 1'b1;
      adc_valid_reg   <= 1'b0;
      // A tick that lands on a running frame is dropped and only reported.
      overrun_reg     <= trigger && (state_reg != IDLE);

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            tx_reg    <= dac_in;
            mosi_reg  <= dac_in[DATA_W-1];
            cs_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= SETUP;
          end
        end

        SETUP: begin
          if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        SHIFT: begin
          // miso is taken at the clk edge that raises sclk, i.e. at the end
          // of the low phase in which the ADC presented the bit.
          if (rise_evt) begin
            rx_reg <= {rx_reg[DATA_W-2:0], miso};
          end
          // mosi only changes with sclk falling, so it is stable across
          // the whole high phase.
          if (fall_evt) begin
            tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
            mosi_reg <= tx_reg[DATA_W-2];
            if (bit_reg == BIT_W'(DATA_W - 1)) begin
              bit_reg   <= '0;
              state_reg <= HOLD;
            end else begin
              bit_reg <= bit_reg + BIT_W'(1);
            end
          end
        end

        HOLD: begin
          if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        DONE: begin
          cs_n_reg      <= 1'b1;
          mosi_reg      <= 1'b0;
          adc_out_reg   <= rx_conv;
          adc_valid_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mosi      = mosi_reg;
  assign cs_n      = cs_n_reg;
  assign adc_out   = adc_out_reg;
  assign adc_valid = adc_valid_reg;
  assign busy      = busy_reg;
  assign overrun   = overrun_reg;

endmodule

// File: doc/spi_sample_frame.md
Name: spi_sample_frame

Overview:
- Converter-side SPI frame engine between the external ADC/DAC and the pedal datapath.
- On each sample tick it runs one full-duplex 16-bit SPI transfer. The transfer shifts the current DAC word out on mosi and captures the ADC word from miso.
- The captured word is converted to two's complement and presented as the new sample with a 1-cycle valid strobe.
- Its output feeds the compression input mux; its DAC word comes from the adder output.

Parameters:
- DATA_W, 16, sample width in bits (transfer length).
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- CS_SETUP, 2, clk cycles from cs_n low to the first sclk rise (>=1).
- CS_HOLD, 2, clk cycles from the last sclk fall to cs_n high (>=1).
- SIGNED_CONV, 1, 1 = ADC word is offset-binary and is converted by inverting the MSB; 0 = pass-through.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- adc_clock  input  1  sample tick level, synchronous to clk; the rising edge starts a frame.
- dac_in  input  DATA_W  word to transmit; latched at frame start.
- miso  input  1  serial data from ADC.
- mosi  output  1  serial data to DAC, MSB first.
- sclk  output  1  SPI clock, mode 0 (idle low).
- cs_n  output  1  converter chip select, active low.
- adc_out  output  DATA_W  last captured sample, two's complement when SIGNED_CONV=1.
- adc_valid  output  1  1-cycle pulse when adc_out updates.
- busy  output  1  high from frame start through DONE.
- overrun  output  1  1-cycle pulse when a tick edge arrives while busy.

Behaviour:
- Reset (rst_n=0 at a clk edge), applies even mid-frame:
  - Outputs: cs_n=1, sclk=0, mosi=0, adc_out=0, adc_valid=0, busy=0, overrun=0.
  - Internals: state=IDLE, counters=0, edge-detect register=0.
  - An adc_clock already high when reset releases does not trigger a frame; only a later 0->1 transition does.
- Edge detect: trigger = adc_clock & ~adc_clock_q. adc_clock_q is registered every cycle.
- IDLE:
  - On trigger: latch dac_in into the tx shift register and go to SETUP.
  - On the same edge: cs_n<=0, busy<=1, mosi<=dac_in[DATA_W-1].
- SETUP:
  - Count CS_SETUP cycles with sclk=0, then go to SHIFT.
- SHIFT:
  - Each sclk half-period lasts CLK_DIV cycles: low phase first, then high phase.
  - Low->high transition: sample miso into the rx shift register, LSB end, shifting left.
  - High->low transition: shift tx and drive the next bit on mosi.
  - After the DATA_W-th high phase ends, sclk=0 and the state goes to HOLD. The bit counter runs 0..DATA_W-1.
  - mosi stays stable throughout each high phase.
- HOLD:
  - Count CS_HOLD cycles with cs_n=0, sclk=0, then go to DONE.
- DONE (1 cycle):
  - cs_n<=1, mosi<=0.
  - adc_out<=rx with the MSB inverted if SIGNED_CONV.
  - adc_valid<=1, busy<=0, return to IDLE.
- Latency: adc_valid asserts CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD + 1 cycles after the trigger cycle. With defaults this is 133.
- Overrun: a trigger in any state other than IDLE is dropped and pulses overrun for 1 cycle. The current frame is unaffected.
- adc_out holds its value between frames. adc_valid is never high for 2 consecutive cycles.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package pedal_pkg holds:
  - SAMPLE_W=16.
  - The frame state enum {IDLE, SETUP, SHIFT, HOLD, DONE}.
  - A function offset_to_twos(word) used here and by the DAC-side formatting.
- Natural sub-module: spi_clk_gen. It contains the CLK_DIV divider and emits sclk plus 1-cycle rise_evt/fall_evt strobes. It runs only while enabled and parks sclk low when disabled.

Test Plan:
- Reset, then one adc_clock 0->1 with dac_in=16'hA5C3 and the bench ADC model returning 16'h8001:
  - Bench slave captures exactly 16'hA5C3 on mosi.
  - adc_out=16'h0001; adc_valid pulses exactly 133 cycles after the trigger cycle.
  - Exactly 16 sclk rises occur while cs_n=0.
- SIGNED_CONV=0 with ADC returning 16'h7FFF -> adc_out=16'h7FFF. SIGNED_CONV=1 with the same ADC word -> adc_out=16'hFFFF.
- Second adc_clock edge 50 cycles after the first trigger -> overrun pulses 1 cycle; only one frame and one adc_valid occur; cs_n shows no glitch.
- adc_clock edges every 134 cycles, 10 frames, ADC returning 16'h8000+i:
  - 10 adc_valid pulses, no overrun.
  - adc_out sequence 0..9; cs_n is high for at least 1 cycle between frames.
- rst_n=0 for 1 cycle at sclk rise #7 -> next cycle cs_n=1, sclk=0, mosi=0, adc_out=0, busy=0; no adc_valid. A fresh edge afterwards completes a normal frame.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 -> adc_valid at trigger+35, with correct data loopback (mosi tied to miso, dac_in=16'h1234, SIGNED_CONV=0 -> adc_out=16'h1234).
